// File: rtl/nand_cmd_seq_pkg.sv
// Shared types for the NAND command/address sequencer: entry encodings,
// FSM states and the delay-counter width.
package nand_cmd_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    CT_CMD  = 2'd0,
    CT_ADDR = 2'd1,
    CT_WAIT = 2'd2,
    CT_END  = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    S_IDLE, S_CE_SETUP, S_ACTIVE, S_LATCH, S_HOLD, S_WAIT, S_CE_HOLD
  } state_e;

  // Counters run count-1 down to 0; a zero count still costs one cycle.
  function automatic logic [CNT_W-1:0] cnt_ld(input int n);
    return (n <= 0) ? '0 : CNT_W'(n - 1);
  endfunction

  function automatic state_e dispatch(input cmd_type_e t);
    case (t)
      CT_CMD, CT_ADDR: return S_LATCH;
      CT_WAIT:         return S_WAIT;
      default:         return S_CE_HOLD;
    endcase
  endfunction
endpackage

// File: rtl/nand_cmd_seq_if.sv
// Entry stream in, PHY control/write-data out.
interface nand_cmd_seq_if #(parameter int DQ_WIDTH = 8);
  import nand_cmd_pkg::*;
  logic                cmd_valid, cmd_ready;
  cmd_type_e           cmd_type;
  logic [DQ_WIDTH-1:0] cmd_data;
  logic                cmd_ce, wp_n, busy;
  logic                ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn;
  logic [1:0]          ctrl_cen;
  logic                dq_oe_n, dqs_oe_n;
  logic [DQ_WIDTH-1:0] wr_data_rise, wr_data_fall;

  modport slave (
    input  cmd_valid, cmd_type, cmd_data, cmd_ce, wp_n,
    output cmd_ready, busy, ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn,
           ctrl_cen, dq_oe_n, dqs_oe_n, wr_data_rise, wr_data_fall
  );
  modport master (
    output cmd_valid, cmd_type, cmd_data, cmd_ce, wp_n,
    input  cmd_ready, busy, ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn,
           ctrl_cen, dq_oe_n, dqs_oe_n, wr_data_rise, wr_data_fall
  );
endinterface

// File: rtl/nand_dly_cnt.sv
// Loadable down-counter; done while the count sits at zero.
module nand_dly_cnt import nand_cmd_pkg::*; (
  input  logic             clk0,
  input  logic             rst0_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n)              r_cnt <= '0;
    else if (i_load)          r_cnt <= i_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/nand_cmd_seq.sv
// ONFI CMD/ADDR latch sequencer: frames CE#, strobes CLE/ALE and spaces cycles
// by TCS/TCAH/TCH; all PHY-facing outputs are Moore flops.
module nand_cmd_seq import nand_cmd_pkg::*; #(
  parameter int DQ_WIDTH = 8,
  parameter int TCS      = 3,
  parameter int TCAH     = 1,
  parameter int TCH      = 2
) (
  input logic           clk0,
  input logic           rst0_n,
  nand_cmd_seq_if.slave bus
);
  state_e              r_state, w_nxt;
  cmd_type_e           r_type, w_type;
  logic [DQ_WIDTH-1:0] r_byte, w_byte, r_wr;
  logic                r_rdy, r_busy, r_cle, r_ale, r_dq_oe_n, r_wpn;
  logic [1:0]          r_cen;
  logic                w_acc, w_done, w_ld;
  logic [CNT_W-1:0]    w_ld_val;

  assign w_acc = bus.cmd_valid & r_rdy;
  // ACTIVE dispatches the live entry; CE_SETUP dispatches the stored opener.
  assign w_type = (r_state == S_ACTIVE) ? bus.cmd_type : r_type;
  assign w_byte = (r_state == S_ACTIVE) ? bus.cmd_data : r_byte;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:         if (w_acc && bus.cmd_type != CT_END) w_nxt = S_CE_SETUP;
      S_CE_SETUP:     if (w_done) w_nxt = dispatch(w_type);
      S_ACTIVE:       if (w_acc)  w_nxt = dispatch(w_type);
      S_LATCH:        w_nxt = S_HOLD;
      S_HOLD, S_WAIT: if (w_done) w_nxt = S_ACTIVE;
      S_CE_HOLD:      if (w_done) w_nxt = S_IDLE;
      default:        w_nxt = S_IDLE;
    endcase
  end

  // Every timed state is entered from a different state, so load on any change.
  always_comb begin
    w_ld     = (w_nxt != r_state);
    w_ld_val = '0;
    case (w_nxt)
      S_CE_SETUP: w_ld_val = cnt_ld(TCS);
      S_HOLD:     w_ld_val = cnt_ld(TCAH);
      S_WAIT:     w_ld_val = cnt_ld(int'(w_byte));
      S_CE_HOLD:  w_ld_val = cnt_ld(TCH);
      default:    w_ld_val = '0;
    endcase
  end

  nand_dly_cnt u_cnt (
    .clk0   (clk0),
    .rst0_n (rst0_n),
    .i_load (w_ld),
    .i_val  (w_ld_val),
    .o_done (w_done)
  );

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_state   <= S_IDLE;
      r_type    <= CT_CMD;
      r_byte    <= '0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_cle     <= 1'b0;
      r_ale     <= 1'b0;
      r_cen     <= 2'b11;
      r_dq_oe_n <= 1'b1;
      r_wr      <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_acc && r_state == S_IDLE) begin
        r_type <= bus.cmd_type;
        r_byte <= bus.cmd_data;
      end
      r_rdy     <= (w_nxt == S_IDLE) || (w_nxt == S_ACTIVE);
      r_busy    <= (w_nxt != S_IDLE);
      r_cle     <= (w_nxt == S_LATCH) && (w_type == CT_CMD);
      r_ale     <= (w_nxt == S_LATCH) && (w_type == CT_ADDR);
      r_dq_oe_n <= !((w_nxt == S_LATCH) || (w_nxt == S_HOLD));
      if (w_nxt == S_LATCH) r_wr <= w_byte;
      // Chip select is fixed by the opening entry and held until release.
      if (w_nxt == S_IDLE)        r_cen <= 2'b11;
      else if (r_state == S_IDLE) r_cen <= bus.cmd_ce ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) r_wpn <= 1'b0;
    else         r_wpn <= bus.wp_n;
  end

  assign bus.cmd_ready    = r_rdy;
  assign bus.busy         = r_busy;
  assign bus.ctrl_cle     = r_cle;
  assign bus.ctrl_ale     = r_ale;
  assign bus.ctrl_wrn     = 1'b1;
  assign bus.ctrl_wpn     = r_wpn;
  assign bus.ctrl_cen     = r_cen;
  assign bus.dq_oe_n      = r_dq_oe_n;
  assign bus.dqs_oe_n     = 1'b1;
  assign bus.wr_data_rise = r_wr;
  assign bus.wr_data_fall = r_wr;
endmodule
